// File: rtl/mem_bus_responder.sv
// Target side of the core's byte-wide memory bus.
// Bus cycles are decoded into on-chip byte RAM or a small I/O window.
// The I/O window fronts a TX FIFO toward the UART and an RX FIFO from it.
// io_buffer_full warns the top level early so it can stall the core
// before the TX FIFO overflows.
module mem_bus_responder #(
  parameter int RAM_AW      = 17,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int TX_PW = $clog2(TX_DEPTH);
  localparam int RX_PW = $clog2(RX_DEPTH);
  localparam logic [TX_PW:0] TX_THRESH = (TX_PW+1)'(TX_DEPTH - FULL_MARGIN);
  localparam logic [TX_PW:0] TX_ONE    = {{TX_PW{1'b0}}, 1'b1};
  localparam logic [RX_PW:0] RX_ONE    = {{RX_PW{1'b0}}, 1'b1};

  // ---- stage p0: combinational decode of the current bus cycle ----
  logic              is_io_p0;
  logic [2:0]        io_reg_p0;
  logic              rd_data_p0;
  logic              wr_data_p0;
  logic              rd_stat_p0;
  logic [RAM_AW-1:0] ram_addr_p0;

  // Address bits above the decoded range carry no meaning here.
  logic unused_addr;
  assign unused_addr = ^mem_a[31:18];

  assign is_io_p0    = (mem_a[17:16] == 2'b11);
  assign io_reg_p0   = mem_a[2:0];
  assign rd_data_p0  = !mem_wr && is_io_p0 && (io_reg_p0 == 3'd0);
  assign wr_data_p0  =  mem_wr && is_io_p0 && (io_reg_p0 == 3'd0);
  assign rd_stat_p0  = !mem_wr && is_io_p0 && (io_reg_p0 == 3'd4);
  assign ram_addr_p0 = mem_a[RAM_AW-1:0];

  // ---- storage ----
  logic [7:0] ram    [0:(1<<RAM_AW)-1];
  logic [7:0] tx_mem [0:TX_DEPTH-1];
  logic [7:0] rx_mem [0:RX_DEPTH-1];

  // ---- control state ----
  logic [TX_PW:0] tx_wptr, tx_rptr;
  logic [RX_PW:0] rx_wptr, rx_rptr;
  logic           ovf;
  logic           rd_data_p1;   // previous cycle was a read of the data register

  // ---- FIFO flags and handshakes ----
  logic           tx_empty, tx_full, rx_empty, rx_full;
  logic           tx_pop, tx_push, rx_pop, rx_push, tx_drop, rx_first;
  logic [TX_PW:0] tx_wptr_nxt, tx_rptr_nxt, tx_count_nxt;
  logic [RX_PW:0] rx_wptr_nxt, rx_rptr_nxt;
  logic [7:0]     status;

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[TX_PW] != tx_rptr[TX_PW]) &&
                    (tx_wptr[TX_PW-1:0] == tx_rptr[TX_PW-1:0]);
  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[RX_PW] != rx_rptr[RX_PW]) &&
                    (rx_wptr[RX_PW-1:0] == rx_rptr[RX_PW-1:0]);

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rptr[TX_PW-1:0]];
  assign rx_ready = !rx_full;

  // A pop frees a slot in the same edge, so a push into a full FIFO
  // is still accepted when the consumer drains one byte concurrently.
  assign tx_pop  = tx_valid && tx_ready;
  assign tx_push = wr_data_p0 && (!tx_full || tx_pop);
  assign tx_drop = wr_data_p0 && !tx_push;

  // Only the first cycle of a held data read pops the RX FIFO.
  assign rx_first = rd_data_p0 && !rd_data_p1;
  assign rx_pop   = rx_first && !rx_empty;
  assign rx_push  = rx_valid && rx_ready;

  assign tx_wptr_nxt  = tx_push ? tx_wptr + TX_ONE : tx_wptr;
  assign tx_rptr_nxt  = tx_pop  ? tx_rptr + TX_ONE : tx_rptr;
  assign tx_count_nxt = tx_wptr_nxt - tx_rptr_nxt;
  assign rx_wptr_nxt  = rx_push ? rx_wptr + RX_ONE : rx_wptr;
  assign rx_rptr_nxt  = rx_pop  ? rx_rptr + RX_ONE : rx_rptr;

  assign status = {5'b0, ovf, !rx_empty, tx_full};

  // ---- stage p1: registered state and read data ----

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr && !is_io_p0) ram[ram_addr_p0] <= mem_dout;
  end

  // FIFO storage writes; data slots are not reset.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr[TX_PW-1:0]] <= mem_dout;
    if (rx_push) rx_mem[rx_wptr[RX_PW-1:0]] <= rx_data;
  end

  // FIFO pointers, sticky overflow, near-full flag and read de-dup history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr        <= '0;
      tx_rptr        <= '0;
      rx_wptr        <= '0;
      rx_rptr        <= '0;
      ovf            <= 1'b0;
      io_buffer_full <= 1'b0;
      rd_data_p1     <= 1'b0;
    end else begin
      tx_wptr        <= tx_wptr_nxt;
      tx_rptr        <= tx_rptr_nxt;
      rx_wptr        <= rx_wptr_nxt;
      rx_rptr        <= rx_rptr_nxt;
      if (tx_drop) ovf <= 1'b1;
      io_buffer_full <= (tx_count_nxt >= TX_THRESH);
      rd_data_p1     <= rd_data_p0;
    end
  end

  // Registered read data; RAM reads return the pre-write byte, held
  // data-register reads keep the byte captured on their first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_din <= 8'h00;
    end else if (!mem_wr) begin
      if (!is_io_p0) begin
        mem_din <= ram[ram_addr_p0];
      end else if (rd_data_p0) begin
        if (rx_first) mem_din <= rx_empty ? 8'h00 : rx_mem[rx_rptr[RX_PW-1:0]];
      end else if (rd_stat_p0) begin
        mem_din <= status;
      end else begin
        mem_din <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: RAM round trip, TX drain/full/overflow,
// RX pop de-duplication, simultaneous push/pop and asynchronous reset.
module tb_mem_bus_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int total = 0;
  int bad   = 0;

  mem_bus_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_a    = 32'h0003_0006;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = 1'b1;
    mem_dout = d;
    tick();
    idle();
  endtask

  task automatic bus_rd(input logic [31:0] a);
    mem_a  = a;
    mem_wr = 1'b0;
    tick();
    idle();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle();
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_mem_din",  mem_din,        8'h00);
    chk("rst_tx_valid", tx_valid,       8'h00);
    chk("rst_rx_ready", rx_ready,       8'h01);
    chk("rst_iobf",     io_buffer_full, 8'h00);
    #3 rst_n = 1'b1;
    tick();
    bus_rd(32'h0003_0004);
    chk("rst_status", mem_din, 8'h00);

    // RAM round trip
    bus_wr(32'h0000_0123, 8'hA5);
    bus_wr(32'h0000_0124, 8'h00);
    bus_rd(32'h0000_0123);
    chk("ram_rd_a5", mem_din, 8'hA5);
    bus_rd(32'h0000_0124);
    chk("ram_rd_00", mem_din, 8'h00);
    bus_rd(32'h0003_0007);
    chk("io_unmapped_rd", mem_din, 8'h00);

    // TX drain in order
    bus_wr(32'h0003_0000, 8'h41);
    bus_wr(32'h0003_0000, 8'h42);
    bus_wr(32'h0003_0000, 8'h43);
    chk("tx2_valid", tx_valid, 8'h01);
    chk("tx2_head",  tx_data,  8'h41);
    tx_ready = 1'b1;
    tick();
    chk("tx2_second", tx_data, 8'h42);
    tick();
    chk("tx2_third", tx_data, 8'h43);
    tick();
    chk("tx2_empty", tx_valid, 8'h00);
    tx_ready = 1'b0;

    // Fill TX to full, watch near-full threshold
    for (int i = 0; i < 16; i++) begin
      bus_wr(32'h0003_0000, 8'(8'h50 + i));
      if (i == 12) chk("iobf_at13", io_buffer_full, 8'h00);
      if (i == 13) chk("iobf_at14", io_buffer_full, 8'h01);
    end
    chk("full_iobf",  io_buffer_full, 8'h01);
    chk("full_head",  tx_data,        8'h50);
    bus_rd(32'h0003_0004);
    chk("full_status", mem_din, 8'h01);

    // Push into a full FIFO while it pops: accepted, no overflow
    tx_ready = 1'b1;
    bus_wr(32'h0003_0000, 8'h99);
    tx_ready = 1'b0;
    chk("simul_head", tx_data, 8'h51);
    chk("simul_iobf", io_buffer_full, 8'h01);
    bus_rd(32'h0003_0004);
    chk("simul_status", mem_din, 8'h01);

    // 17th byte with no pop is dropped and flags overflow
    bus_wr(32'h0003_0000, 8'hEE);
    bus_rd(32'h0003_0004);
    chk("ovf_status", mem_din, 8'h05);

    // Drain: 0x51..0x5F then 0x99; dropped 0xEE never appears
    tx_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("drain_valid", tx_valid, 8'h01);
      chk("drain_data",  tx_data,  (k < 15) ? 8'(8'h51 + k) : 8'h99);
      tick();
    end
    tx_ready = 1'b0;
    chk("drain_empty", tx_valid,       8'h00);
    chk("drain_iobf",  io_buffer_full, 8'h00);

    // RX pop de-duplication
    rx_valid = 1'b1;
    rx_data  = 8'h10;
    tick();
    rx_data  = 8'h20;
    tick();
    rx_valid = 1'b0;
    mem_a  = 32'h0003_0000;
    mem_wr = 1'b0;
    tick();
    chk("rx_hold1", mem_din, 8'h10);
    tick();
    chk("rx_hold2", mem_din, 8'h10);
    tick();
    chk("rx_hold3", mem_din, 8'h10);
    idle();
    bus_rd(32'h0003_0004);
    chk("rx_status_one", mem_din, 8'h06);
    bus_rd(32'h0003_0000);
    chk("rx_second", mem_din, 8'h20);
    bus_rd(32'h0003_0004);
    chk("rx_status_empty", mem_din, 8'h04);
    bus_rd(32'h0003_0000);
    chk("rx_empty_rd", mem_din, 8'h00);

    // RX full drops rx_ready
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'h60 + i);
      tick();
    end
    rx_valid = 1'b0;
    chk("rx_full_ready", rx_ready, 8'h00);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 14; i++) bus_wr(32'h0003_0000, 8'(8'h70 + i));
    chk("pre_rst_iobf", io_buffer_full, 8'h01);
    bus_rd(32'h0000_0123);
    chk("pre_rst_din", mem_din, 8'hA5);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", tx_valid,       8'h00);
    chk("arst_iobf",     io_buffer_full, 8'h00);
    chk("arst_mem_din",  mem_din,        8'h00);
    chk("arst_rx_ready", rx_ready,       8'h01);
    #1 rst_n = 1'b1;
    bus_rd(32'h0000_0123);
    chk("post_rst_ram", mem_din, 8'hA5);
    bus_rd(32'h0003_0004);
    chk("post_rst_status", mem_din, 8'h00);
    chk("post_rst_tx_valid", tx_valid, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
